// File: rtl/dmem_arbiter.sv
// Two-port req/gnt arbiter in front of a single-port data memory, with registered responses.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_WORDS = 64,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wdata,
  output logic          o_m0_gnt,
  output logic          o_m0_rvalid,
  output logic [DW-1:0] o_m0_rdata,
  output logic          o_m0_err,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wdata,
  output logic          o_m1_gnt,
  output logic          o_m1_rvalid,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_m1_err,
  output logic          o_mem_write,
  output logic          o_mem_read,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  // Response FSM, one per port:
  //   state   | meaning
  //   ST_IDLE | no response this cycle
  //   ST_RESP | response valid (granted on the previous edge)
  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  localparam logic [AW-1:0] LP_LIMIT = AW'(ADDR_WORDS);

  state_t        r_state0, r_state1;
  state_t        w_state0_nx, w_state1_nx;
  logic          w_p0_wins;
  logic          w_gnt0, w_gnt1;
  logic          w_inr0, w_inr1;
  logic [DW-1:0] r_rdata0, r_rdata1;
  logic          r_err0, r_err1;

  assign w_inr0 = (i_m0_addr < LP_LIMIT);
  assign w_inr1 = (i_m1_addr < LP_LIMIT);

`ifdef DMEM_ARB_RR_EN
  // r_last = 1 means port 1 was granted most recently, so port 0 wins a tie.
  logic r_last;

  assign w_p0_wins = !i_m1_req || r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last <= 1'b1;
    else if (w_gnt0) r_last <= 1'b0;
    else if (w_gnt1) r_last <= 1'b1;
  end
`else
  assign w_p0_wins = 1'b1;
`endif

  assign w_gnt0   = i_m0_req && w_p0_wins;
  assign w_gnt1   = i_m1_req && !w_gnt0;
  assign o_m0_gnt = w_gnt0;
  assign o_m1_gnt = w_gnt1;

  // Out-of-range accesses are granted but never reach the memory.
  always_comb begin
    o_mem_write = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt0 && w_inr0) begin
      o_mem_write = i_m0_we;
      o_mem_read  = !i_m0_we;
      o_mem_addr  = i_m0_addr;
      o_mem_wdata = i_m0_wdata;
    end else if (w_gnt1 && w_inr1) begin
      o_mem_write = i_m1_we;
      o_mem_read  = !i_m1_we;
      o_mem_addr  = i_m1_addr;
      o_mem_wdata = i_m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_err0   <= 1'b0;
      r_rdata1 <= '0;
      r_err1   <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_err0   <= !w_inr0;
        r_rdata0 <= (w_inr0 && !i_m0_we) ? i_mem_rdata : '0;
      end
      if (w_gnt1) begin
        r_err1   <= !w_inr1;
        r_rdata1 <= (w_inr1 && !i_m1_we) ? i_mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state0 <= ST_IDLE;
      r_state1 <= ST_IDLE;
    end else begin
      r_state0 <= w_state0_nx;
      r_state1 <= w_state1_nx;
    end
  end

  always_comb begin
    w_state0_nx = r_state0;
    w_state1_nx = r_state1;
    case (r_state0)
      ST_IDLE: if (w_gnt0)  w_state0_nx = ST_RESP;
      ST_RESP: if (!w_gnt0) w_state0_nx = ST_IDLE;
      default: w_state0_nx = ST_IDLE;
    endcase
    case (r_state1)
      ST_IDLE: if (w_gnt1)  w_state1_nx = ST_RESP;
      ST_RESP: if (!w_gnt1) w_state1_nx = ST_IDLE;
      default: w_state1_nx = ST_IDLE;
    endcase
  end

  assign o_m0_rvalid = (r_state0 == ST_RESP);
  assign o_m1_rvalid = (r_state1 == ST_RESP);
  assign o_m0_rdata  = r_rdata0;
  assign o_m1_rdata  = r_rdata1;
  assign o_m0_err    = r_err0;
  assign o_m1_err    = r_err1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus held-until-granted random traffic,
// checked against a transaction-level model of arbitration, memory and responses.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  // Memory attached to the DUT's memory port.
  logic [31:0] tb_mem [64];
  always @(posedge clk) if (mem_write && mem_addr < 64) tb_mem[mem_addr[5:0]] <= mem_wdata;
  assign mem_rdata = (mem_read && mem_addr < 64) ? tb_mem[mem_addr[5:0]] : 32'h0BAD0BAD;

  // Reference model state.
  logic [31:0] ref_mem [64];
  logic        m_last = 1'b1;
  logic        m_rv0 = 0, m_rv1 = 0, m_err0 = 0, m_err1 = 0;
  logic [31:0] m_rd0 = 0, m_rd1 = 0;
  logic        last_g0, last_g1;

  // Random requester state (held until granted).
  logic        p_req [2];
  logic        p_we  [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd  [2];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WORDS(64), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata), .o_m0_err(m0_err),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata), .o_m1_err(m1_err),
    .o_mem_write(mem_write), .o_mem_read(mem_read), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_responses();
    chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, m_rv0});
    chk("m0_rdata",  m0_rdata,           m_rd0);
    chk("m0_err",    {31'b0, m0_err},    {31'b0, m_err0});
    chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, m_rv1});
    chk("m1_rdata",  m1_rdata,           m_rd1);
    chk("m1_err",    {31'b0, m1_err},    {31'b0, m_err1});
  endtask

  // One cycle: drive at negedge, check, then advance the model past the next rising edge.
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic        eg0, eg1, inr0, inr1;
    logic        ew, er;
    logic [31:0] ea, ed;
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    check_responses();
    if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
      eg0 = m_last;
`else
      eg0 = 1'b1;
`endif
      eg1 = !eg0;
    end else begin
      eg0 = r0;
      eg1 = r1;
    end
    inr0 = (a0 < 64);
    inr1 = (a1 < 64);
    ew = 0; er = 0; ea = 0; ed = 0;
    if (eg0 && inr0) begin ew = w0; er = !w0; ea = a0; ed = d0; end
    if (eg1 && inr1) begin ew = w1; er = !w1; ea = a1; ed = d1; end
    chk("m0_gnt",    {31'b0, m0_gnt},    {31'b0, eg0});
    chk("m1_gnt",    {31'b0, m1_gnt},    {31'b0, eg1});
    chk("mem_write", {31'b0, mem_write}, {31'b0, ew});
    chk("mem_read",  {31'b0, mem_read},  {31'b0, er});
    chk("mem_addr",  mem_addr,           ea);
    chk("mem_wdata", mem_wdata,          ed);
    m_rv0 = eg0;
    m_rv1 = eg1;
    if (eg0) begin m_err0 = !inr0; m_rd0 = (inr0 && !w0) ? ref_mem[a0[5:0]] : 32'h0; end
    if (eg1) begin m_err1 = !inr1; m_rd1 = (inr1 && !w1) ? ref_mem[a1[5:0]] : 32'h0; end
    if (eg0 && inr0 && w0) ref_mem[a0[5:0]] = d0;
    if (eg1 && inr1 && w1) ref_mem[a1[5:0]] = d1;
    if (eg0) m_last = 1'b0;
    if (eg1) m_last = 1'b1;
    last_g0 = eg0;
    last_g1 = eg1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m0_gnt"},    {31'b0, m0_gnt},    0);
    chk({tag, "_m1_gnt"},    {31'b0, m1_gnt},    0);
    chk({tag, "_m0_rvalid"}, {31'b0, m0_rvalid}, 0);
    chk({tag, "_m1_rvalid"}, {31'b0, m1_rvalid}, 0);
    chk({tag, "_m0_rdata"},  m0_rdata,           0);
    chk({tag, "_m1_rdata"},  m1_rdata,           0);
    chk({tag, "_m0_err"},    {31'b0, m0_err},    0);
    chk({tag, "_m1_err"},    {31'b0, m1_err},    0);
    chk({tag, "_mem_write"}, {31'b0, mem_write}, 0);
    chk({tag, "_mem_read"},  {31'b0, mem_read},  0);
    chk({tag, "_mem_addr"},  mem_addr,           0);
    chk({tag, "_mem_wdata"}, mem_wdata,          0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'd64 + 32'($urandom_range(0, 3));
    if (r == 1) return $urandom;
    return 32'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    p_req[0] = 0; p_req[1] = 0;
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;

    // First tie after reset goes to port 0 in either arbitration mode.
    step(1, 1, 10, 32'hAAAA0000, 1, 1, 11, 32'hBBBB1111);
    chk("first_tie_gnt0", {31'b0, last_g0}, 1);
    step(0, 0, 0, 0, 1, 1, 11, 32'hBBBB1111);

    // Preload every word so later reads have defined data.
    for (int i = 0; i < 64; i++) step(1, 1, i, 32'h1000 + i * 3, 0, 0, 0, 0);
    idle();

    // Port 0 write then read back.
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 5, 0, 0, 0, 0, 0);
    idle();
    chk("p0_readback", m0_rdata, 32'hDEADBEEF);

    // Sustained contention.
    for (int i = 0; i < 6; i++) step(1, 0, i, 0, 1, 0, 8 + i, 0);
    idle();

    // Out-of-range write from port 1.
    step(0, 0, 0, 0, 1, 1, 64, 32'h12345678);
    idle();
    chk("oor_err", {31'b0, m1_err}, 1);
    chk("oor_mem0", tb_mem[0], ref_mem[0]);

    // Back-to-back reads on port 1 after preload.
    step(1, 1, 0, 7, 0, 0, 0, 0);
    step(1, 1, 1, 8, 0, 0, 0, 0);
    step(1, 1, 2, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 2, 0);
    idle();
    chk("b2b_last_rdata", m1_rdata, 32'd9);
    idle();

    // Reset in the middle of a pending response.
    step(1, 0, 5, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_reset_rvalid", {31'b0, m0_rvalid}, 1);
    m0_req = 0; m1_req = 0;
    m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    rst_n = 0;
    #1;
    check_all_zero("midreset");
    m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0; m_err0 = 0; m_err1 = 0; m_last = 1'b1;
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 3, 0, 1, 0, 4, 0);
    chk("post_reset_tie_gnt0", {31'b0, last_g0}, 1);

    // Random traffic; each requester holds its transaction until granted.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && $urandom_range(0, 9) < 6) begin
          p_req[p]  = 1;
          p_we[p]   = $urandom_range(0, 1) == 1;
          p_addr[p] = rand_addr();
          p_wd[p]   = $urandom;
        end
      end
      step(p_req[0], p_we[0], p_addr[0], p_wd[0], p_req[1], p_we[1], p_addr[1], p_wd[1]);
      if (last_g0) p_req[0] = 0;
      if (last_g1) p_req[1] = 0;
    end
    idle();
    idle();
    for (int i = 0; i < 64; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed in front of the single-port 64-word data memory of the single-core RISC-V. It shares that memory between the core load/store path (port 0) and a debug/DMA port (port 1). It uses a per-port req/gnt handshake, issues at most one access per cycle, and returns a registered read response one cycle after grant. It also blocks out-of-range word addresses and reports them as errors.

## Interface
Parameters:
- ADDR_WORDS, 64: number of memory words. Valid word addresses are 0..ADDR_WORDS-1.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mN_req  in  1  port N (N=0,1) access request, held until granted.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  AW  word index.
- mN_wdata  in  DW  write data.
- mN_gnt  out  1  request accepted this cycle (combinational).
- mN_rvalid  out  1  response valid, one cycle after gnt.
- mN_rdata  out  DW  read data; 0 for writes and for errors.
- mN_err  out  1  response error flag (address out of range).
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory combinational read data.

## Operation
- **Grant rule.** At most one of m0_gnt/m1_gnt is high in a cycle. A request is granted only if mN_req=1.
- **Arbitration with DMEM_ARB_RR_EN.** Round-robin pointer `last`, which resets to 1 so port 0 wins the first tie. On a tie, the port != `last` wins. `last` updates to the granted port at each grant.
- **Arbitration without DMEM_ARB_RR_EN.** Fixed priority, port 0 always wins. `last` is not implemented.
- **Memory drive, granted and in range.** mem_addr=mN_addr, mem_wdata=mN_wdata, mem_write=mN_we, mem_read=!mN_we.
- **Memory drive, no grant or out of range.** mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
- **Out of range** means mN_addr >= ADDR_WORDS. The access is still granted and consumed, but no memory strobe is issued.
- **Response register**, per port, loaded at the grant edge:
  - rvalid=1.
  - err = out-of-range.
  - rdata = mem_rdata for an in-range read, else 0.
  - Ungranted port: rvalid=0. rdata and err hold their previous values.
- **Response FSM**, per port: IDLE -> RESP on grant. RESP -> RESP on a back-to-back grant. RESP -> IDLE with no grant.
- **Throughput.** One access per cycle. No backpressure on responses; requesters must accept rvalid unconditionally.

## Timing
- **Reset values.** All outputs 0 (gnt, rvalid, rdata, err, mem_*). FSMs in IDLE. `last`=1.
- **Grant latency.** Same cycle as req when the port wins arbitration.
- **Write.** The memory captures mem_wdata at the grant edge. rvalid=1 with rdata=0 in the next cycle.
- **Read.** mem_rdata is sampled at the grant edge. rdata is valid with rvalid in the next cycle, for one cycle per grant.
- **Write and read to the same address in consecutive cycles.** The read returns the new data.
- **Reset mid-operation.** Reset asserted while rvalid=1 clears rvalid immediately (asynchronous). The pending response is lost and no retry is performed.
- **Losing requester.** Must hold req, we, addr and wdata stable until gnt. A change before gnt is undefined.
- **Address width.** Full AW bits are compared; no truncation or wrap-around.

## Configuration
- **DMEM_ARB_RR_EN defined.** Round-robin arbitration. Under continuous contention, grants alternate 0,1,0,1,…
- **DMEM_ARB_RR_EN undefined.** Fixed priority to port 0. Port 1 is starved while m0_req stays high.

## Test plan
- **Reset state.** Assert rst_n=0 mid-run with rvalid high -> all outputs 0 immediately. After release, the first simultaneous request grants port 0.
- **Port 0 write/read.**
  - m0 writes 0xDEADBEEF at addr 5 -> mem_write=1 that cycle; next cycle m0_rvalid=1, m0_rdata=0.
  - m0 then reads addr 5 -> the cycle after, m0_rdata=0xDEADBEEF.
- **Contention, DMEM_ARB_RR_EN defined.** Both req held for 6 cycles -> grants 0,1,0,1,0,1. Each rvalid follows its gnt by one cycle.
- **Contention, DMEM_ARB_RR_EN undefined.** Both req held for 4 cycles -> m0_gnt every cycle, m1_gnt=0. Drop m0_req -> m1_gnt in the same cycle.
- **Out of range.** m1 writes addr 64 -> gnt=1, mem_write=0, memory unchanged. Next cycle m1_rvalid=1, m1_err=1, m1_rdata=0.
- **Back-to-back.** m1 reads addr 0,1,2 on consecutive cycles after preload 7,8,9 -> rvalid high for 3 cycles with rdata 7,8,9. The FSM stays in RESP, then returns to IDLE.
